full_adder_checker: RTL and testbench
=====================================

Name: full_adder_checker

Overview:
- Synthesizable, self-checking exerciser for the 1-bit full_adder; it is the response side of the adder stimulus flow.
- Drives all 8 {A,B,Cin} vectors into a DUT and waits a programmable settle time per vector.
- Samples S/Cout and compares them against the expected sum and carry.
- Reports a pass flag, an error count and a per-vector failure bitmap, so the adder can be checked on the board (switch-triggered, LED-reported) without a simulator.

Parameters:
- SETTLE_CYCLES, 4, number of extra cycles each vector is held before sampling. Legal range 1..255; 0 is illegal.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  level-sampled run request; accepted only when not busy
- A  output  1  DUT operand A (vector bit 2)
- B  output  1  DUT operand B (vector bit 1)
- Cin  output  1  DUT carry-in (vector bit 0)
- S  input  1  DUT sum
- Cout  input  1  DUT carry-out
- busy  output  1  run in progress
- done  output  1  run complete; held until the next accepted start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  4  number of mismatching vectors in the last run (0..8)
- fail_vec  output  8  bit v set iff vector v mismatched

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n: while rst_n=0 at a rising edge, all state is reset.
- Reset values: A=B=Cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, state=IDLE, vector index v=0, settle counter=0.
- States:
  - IDLE: start=1 at edge E0 -> RUN. At E0: v=0, {A,B,Cin}=3'b000, busy=1, done=0, pass=0, err_count=0, fail_vec=0, settle counter=0.
  - RUN: the settle counter increments each edge while {A,B,Cin}=v[2:0] is held.
  - Sample point: the edge at which the counter has reached SETTLE_CYCLES. Each vector is therefore held exactly SETTLE_CYCLES+1 cycles.
  - At the sample point, compute expected S = A^B^Cin and expected Cout = (A&B)|(A&Cin)|(B&Cin) from the held vector. If S or Cout differs: err_count+1 and fail_vec[v]=1, same edge.
  - At the sample point with v<7: v+1, drive the new vector on that same edge, counter=0.
  - At the sample point with v==7: -> FIN, {A,B,Cin}=0.
  - FIN (one cycle): busy=0, done=1, pass=(err_count==0) -> DONE.
  - DONE: outputs held. start=1 -> behaves exactly as start in IDLE (new run, results cleared).
- Timing: the final sample is at E0+8*(SETTLE_CYCLES+1). done/pass assert at E0+8*(SETTLE_CYCLES+1)+1 (41 cycles after E0 by default).
- start while busy=1: ignored; no restart and no effect on the results.
- S/Cout are treated as synchronous to clk and are sampled only at sample points; values between sample points are ignored.
- rst_n=0 mid-run: the next edge applies the reset values; done is never asserted for the aborted run. A start after reset release runs normally.
- err_count never exceeds 8; no saturation logic is needed.

Test Plan:
- Ideal combinational adder, SETTLE_CYCLES=4, 1-cycle start pulse -> vectors 000..111 each held 5 cycles. done=1 at 41 cycles after start; pass=1, err_count=0, fail_vec=8'h00, busy=0.
- DUT with S stuck-at-0 -> vectors 1,2,4,7 fail. fail_vec=8'b1001_0110, err_count=4, pass=0.
- DUT with Cout stuck-at-1 -> vectors 0,1,2,4 fail. fail_vec=8'b0001_0111, err_count=4, pass=0.
- start re-asserted 10 cycles into the run -> ignored. done still at cycle 41, results unchanged. A second start in DONE with an ideal DUT after a faulty run -> err_count=0, fail_vec=0, pass=1.
- rst_n=0 for one edge at cycle 20 of the run -> next edge: A=B=Cin=0, busy=0, done=0, err_count=0. A fresh start then completes normally.
- DUT outputs delayed by 3 registered cycles: SETTLE_CYCLES=4 -> pass=1. SETTLE_CYCLES=1 -> pass=0 with err_count>0.

Source files
------------

// File: rtl/full_adder_checker_if.sv
// full_adder_checker_if: vector/response bus between the checker and the adder under test
interface full_adder_checker_if;
   logic A;
   logic B;
   logic Cin;
   logic S;
   logic Cout;
   modport master (output A, B, Cin, input S, Cout);
   modport slave (input A, B, Cin, output S, Cout);
endinterface

// File: rtl/full_adder_checker.sv
// full_adder_checker: walks all 8 full-adder input vectors and scores the responses
module full_adder_checker #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   full_adder_checker_if.master        dut,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [3:0]                  err_count,
   output logic [7:0]                  fail_vec
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

   logic [1:0] state_q, state_d;
   logic [2:0] v_q, v_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] abc_q, abc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [7:0] fail_q, fail_d;
   logic       exp_s, exp_c, mismatch;

   assign exp_s    = ^abc_q;
   assign exp_c    = (abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0]);
   assign mismatch = (dut.S != exp_s) || (dut.Cout != exp_c);

   // next-state: accept start when idle/done, hold and sample each vector, then publish results
   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      abc_d   = abc_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;
      if ((state_q == IDLE || state_q == DONE) && start) begin
         state_d = RUN;
         v_d     = 3'd0;
         cnt_d   = 8'd0;
         abc_d   = 3'd0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         err_d   = 4'd0;
         fail_d  = 8'd0;
      end else if (state_q == RUN) begin
         if (cnt_q == SETTLE) begin
            if (mismatch) begin
               err_d  = err_q + 4'd1;
               fail_d = fail_q | (8'd1 << v_q);
            end
            if (v_q != 3'd7) begin
               v_d   = v_q + 3'd1;
               abc_d = v_q + 3'd1;
               cnt_d = 8'd0;
            end else begin
               state_d = FIN;
               abc_d   = 3'd0;
            end
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (state_q == FIN) begin
         state_d = DONE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         pass_d  = (err_q == 4'd0);
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         v_q     <= 3'd0;
         cnt_q   <= 8'd0;
         abc_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'd0;
         fail_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
         abc_q   <= abc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   assign dut.A     = abc_q[2];
   assign dut.B     = abc_q[1];
   assign dut.Cin   = abc_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;
endmodule

// File: tb/tb_full_adder_checker.sv
// tb_full_adder_checker: directed scoreboard bench driving ideal, faulty and delayed adder models
module tb_full_adder_checker;
   typedef struct {
      string      tag;
      logic       pass;
      logic [3:0] err;
      logic [7:0] fail;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   int   mode = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [3:0] err0, err1;
   logic [7:0] fail0, fail1;
   logic [1:0] p1, p2, p3, q1, q2, q3;
   logic       s0, c0, s1, c1;

   full_adder_checker_if ifa ();
   full_adder_checker_if ifb ();

   always #5 clk = ~clk;

   full_adder_checker #(.SETTLE_CYCLES(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .dut(ifa.master),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
   );

   full_adder_checker #(.SETTLE_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut(ifb.master),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
   );

   assign s0 = ifa.A ^ ifa.B ^ ifa.Cin;
   assign c0 = (ifa.A & ifa.B) | (ifa.A & ifa.Cin) | (ifa.B & ifa.Cin);
   assign s1 = ifb.A ^ ifb.B ^ ifb.Cin;
   assign c1 = (ifb.A & ifb.B) | (ifb.A & ifb.Cin) | (ifb.B & ifb.Cin);

   // three-register response delay models for both adders
   always @(posedge clk) begin
      p1 <= {s0, c0};
      p2 <= p1;
      p3 <= p2;
      q1 <= {s1, c1};
      q2 <= q1;
      q3 <= q2;
   end

   // mode 0 ideal, 1 S stuck-at-0, 2 Cout stuck-at-1, 3 delayed by three registers
   assign ifa.S    = (mode == 1) ? 1'b0 : (mode == 3) ? p3[1] : s0;
   assign ifa.Cout = (mode == 2) ? 1'b1 : (mode == 3) ? p3[0] : c0;
   assign ifb.S    = q3[1];
   assign ifb.Cout = q3[0];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start0();
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   // follow one u0 run from the negedge after the accepting edge, checking vectors and busy, then score it
   task automatic run0(input int restart_at);
      int   n;
      exp_t e;
      n = 0;
      while (n < 100 && !done0) begin
         check("vector", 32'({ifa.A, ifa.B, ifa.Cin}), (n < 40) ? n / 5 : 0);
         check("busy_run", 32'(busy0), 1);
         start0 = (n == restart_at);
         @(negedge clk);
         n++;
      end
      start0 = 1'b0;
      e = sb.pop_front();
      check({e.tag, "_lat"}, n, e.lat);
      check({e.tag, "_pass"}, 32'(pass0), 32'(e.pass));
      check({e.tag, "_err"}, 32'(err0), 32'(e.err));
      check({e.tag, "_fail"}, 32'(fail0), 32'(e.fail));
      check({e.tag, "_busy"}, 32'(busy0), 0);
   endtask

   initial begin
      int n;
      repeat (4) @(negedge clk);
      check("rst_abc", 32'({ifa.A, ifa.B, ifa.Cin}), 0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_pass", 32'(pass0), 0);
      check("rst_err", 32'(err0), 0);
      check("rst_fail", 32'(fail0), 0);
      check("rst_u1_done", 32'(done1), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      mode = 0;
      sb.push_back('{"ideal", 1'b1, 4'd0, 8'h00, 41});
      pulse_start0();
      run0(-1);
      repeat (3) @(negedge clk);
      check("done_held", 32'(done0), 1);

      mode = 1;
      sb.push_back('{"s_sa0", 1'b0, 4'd4, 8'h96, 41});
      pulse_start0();
      run0(-1);

      mode = 2;
      sb.push_back('{"c_sa1", 1'b0, 4'd4, 8'h17, 41});
      pulse_start0();
      run0(-1);

      mode = 0;
      sb.push_back('{"restart", 1'b1, 4'd0, 8'h00, 41});
      pulse_start0();
      run0(10);

      mode = 1;
      pulse_start0();
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_abc", 32'({ifa.A, ifa.B, ifa.Cin}), 0);
      check("mid_rst_busy", 32'(busy0), 0);
      check("mid_rst_done", 32'(done0), 0);
      check("mid_rst_err", 32'(err0), 0);
      repeat (50) @(negedge clk);
      check("aborted_no_done", 32'(done0), 0);

      mode = 0;
      sb.push_back('{"after_rst", 1'b1, 4'd0, 8'h00, 41});
      pulse_start0();
      run0(-1);

      mode = 3;
      sb.push_back('{"delay3", 1'b1, 4'd0, 8'h00, 41});
      pulse_start0();
      run0(-1);

      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (n < 100 && !done1) begin
         @(negedge clk);
         n++;
      end
      check("u1_lat", n, 17);
      check("u1_pass", 32'(pass1), 0);
      check("u1_err_nonzero", 32'(err1 != 4'd0), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
